// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the 32-bit EX ALU: decode, operand forwarding, stall/flush, illegal-funct count.
// Optional build macro: ALU_ISSUE_FWD_EN enables EX/MEM and MEM/WB operand forwarding.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt_in,
  input  logic [4:0]       rs_idx,
  input  logic [4:0]       rt_idx,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic [WIDTH-1:0] imm,
  input  logic             alusrc,
  input  logic             exmem_we,
  input  logic [4:0]       exmem_rd,
  input  logic [WIDTH-1:0] exmem_y,
  input  logic             memwb_we,
  input  logic [4:0]       memwb_rd,
  input  logic [WIDTH-1:0] memwb_wd,
  output logic             ex_valid,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [2:0]       ex_f,
  output logic [4:0]       ex_shamt,
  output logic             ex_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned F_W  = 3;
  localparam int unsigned SH_W = 5;

  logic [F_W-1:0]   f_c;
  logic             illegal_c;
  logic [WIDTH-1:0] opa_c;
  logic [WIDTH-1:0] rt_fwd_c;
  logic [WIDTH-1:0] opb_c;

  logic             ex_valid_q,   ex_valid_d;
  logic [WIDTH-1:0] ex_a_q,       ex_a_d;
  logic [WIDTH-1:0] ex_b_q,       ex_b_d;
  logic [F_W-1:0]   ex_f_q,       ex_f_d;
  logic [SH_W-1:0]  ex_shamt_q,   ex_shamt_d;
  logic             ex_illegal_q, ex_illegal_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;

  // ALUOp/funct to ALU function code; unknown R-type funct decodes to AND and is flagged
  always_comb begin
    f_c       = F_W'(0);
    illegal_c = 1'b0;
    case (aluop)
      2'b00: f_c = F_W'(2);
      2'b01: f_c = F_W'(6);
      2'b11: f_c = F_W'(1);
      default: begin
        case (funct)
          6'h20:   f_c = F_W'(2);
          6'h22:   f_c = F_W'(6);
          6'h24:   f_c = F_W'(0);
          6'h25:   f_c = F_W'(1);
          6'h2A:   f_c = F_W'(7);
          default: illegal_c = 1'b1;
        endcase
      end
    endcase
  end

`ifdef ALU_ISSUE_FWD_EN
  // Youngest producer wins: EX/MEM before MEM/WB; register 0 is never forwarded
  always_comb begin
    opa_c = rs_val;
    if (exmem_we && (exmem_rd == rs_idx) && (rs_idx != 5'd0)) begin
      opa_c = exmem_y;
    end else if (memwb_we && (memwb_rd == rs_idx) && (rs_idx != 5'd0)) begin
      opa_c = memwb_wd;
    end
    rt_fwd_c = rt_val;
    if (exmem_we && (exmem_rd == rt_idx) && (rt_idx != 5'd0)) begin
      rt_fwd_c = exmem_y;
    end else if (memwb_we && (memwb_rd == rt_idx) && (rt_idx != 5'd0)) begin
      rt_fwd_c = memwb_wd;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_we, exmem_rd, exmem_y, memwb_we, memwb_rd, memwb_wd, rs_idx, rt_idx};
  assign opa_c      = rs_val;
  assign rt_fwd_c   = rt_val;
`endif

  assign opb_c = alusrc ? imm : rt_fwd_c;

  // Next EX contents: flush beats stall beats load
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_a_d       = ex_a_q;
    ex_b_d       = ex_b_q;
    ex_f_d       = ex_f_q;
    ex_shamt_d   = ex_shamt_q;
    ex_illegal_d = ex_illegal_q;
    cnt_d        = cnt_q;
    if (flush) begin
      ex_valid_d   = 1'b0;
      ex_a_d       = '0;
      ex_b_d       = '0;
      ex_f_d       = '0;
      ex_shamt_d   = '0;
      ex_illegal_d = 1'b0;
    end else if (!stall) begin
      ex_valid_d   = in_valid;
      ex_a_d       = opa_c;
      ex_b_d       = opb_c;
      ex_f_d       = f_c;
      ex_shamt_d   = shamt_in;
      ex_illegal_d = in_valid & illegal_c;
      if (in_valid && illegal_c && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q   <= 1'b0;
      ex_a_q       <= '0;
      ex_b_q       <= '0;
      ex_f_q       <= '0;
      ex_shamt_q   <= '0;
      ex_illegal_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_a_q       <= ex_a_d;
      ex_b_q       <= ex_b_d;
      ex_f_q       <= ex_f_d;
      ex_shamt_q   <= ex_shamt_d;
      ex_illegal_q <= ex_illegal_d;
      cnt_q        <= cnt_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_a        = ex_a_q;
  assign ex_b        = ex_b_q;
  assign ex_f        = ex_f_q;
  assign ex_shamt    = ex_shamt_q;
  assign ex_illegal  = ex_illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, stall/flush, reset, forwarding and counter saturation.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n, stall, flush, in_valid, alusrc;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [4:0]  shamt_in, rs_idx, rt_idx, exmem_rd, memwb_rd;
  logic [31:0] rs_val, rt_val, imm, exmem_y, memwb_wd;
  logic        exmem_we, memwb_we;

  logic        ex_valid, ex_illegal, ex_valid2, ex_illegal2;
  logic [31:0] ex_a, ex_b, ex_a2, ex_b2;
  logic [2:0]  ex_f, ex_f2;
  logic [4:0]  ex_shamt, ex_shamt2;
  logic [7:0]  illegal_cnt;
  logic [1:0]  illegal_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_stage u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .aluop(aluop), .funct(funct), .shamt_in(shamt_in), .rs_idx(rs_idx), .rt_idx(rt_idx),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .alusrc(alusrc),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_y(exmem_y),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_wd(memwb_wd),
    .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_f(ex_f), .ex_shamt(ex_shamt),
    .ex_illegal(ex_illegal), .illegal_cnt(illegal_cnt)
  );

  alu_issue_stage #(.WIDTH(32), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .aluop(aluop), .funct(funct), .shamt_in(shamt_in), .rs_idx(rs_idx), .rt_idx(rt_idx),
    .rs_val(rs_val), .rt_val(rt_val), .imm(imm), .alusrc(alusrc),
    .exmem_we(exmem_we), .exmem_rd(exmem_rd), .exmem_y(exmem_y),
    .memwb_we(memwb_we), .memwb_rd(memwb_rd), .memwb_wd(memwb_wd),
    .ex_valid(ex_valid2), .ex_a(ex_a2), .ex_b(ex_b2), .ex_f(ex_f2), .ex_shamt(ex_shamt2),
    .ex_illegal(ex_illegal2), .illegal_cnt(illegal_cnt2)
  );

  typedef struct {
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [4:0]  sh;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic        alusrc;
    logic        e_valid;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [2:0]  e_f;
    logic [4:0]  e_sh;
    logic        e_ill;
    logic [7:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic ev, input logic [31:0] ea,
                           input logic [31:0] eb, input logic [2:0] ef, input logic [4:0] es,
                           input logic eil, input logic [7:0] ecnt);
    check($sformatf("%s.valid", name), 32'(ex_valid), 32'(ev));
    check($sformatf("%s.a", name), ex_a, ea);
    check($sformatf("%s.b", name), ex_b, eb);
    check($sformatf("%s.f", name), 32'(ex_f), 32'(ef));
    check($sformatf("%s.shamt", name), 32'(ex_shamt), 32'(es));
    check($sformatf("%s.illegal", name), 32'(ex_illegal), 32'(eil));
    check($sformatf("%s.cnt", name), 32'(illegal_cnt), 32'(ecnt));
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [4:0] sh, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] im, input logic src);
    in_valid = v; aluop = op; funct = fn; shamt_in = sh;
    rs_val = rs; rt_val = rt; imm = im; alusrc = src;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 2'b10, 6'h2A, 5'd0,  32'hFFFFFFFB, 32'd3, 32'd0, 1'b0,
                 1'b1, 32'hFFFFFFFB, 32'd3, 3'd7, 5'd0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 2'b00, 6'h03, 5'd4,  32'd1, 32'd9, 32'hFFFFFFFC, 1'b1,
                 1'b1, 32'd1, 32'hFFFFFFFC, 3'd2, 5'd4, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 2'b01, 6'h00, 5'd7,  32'd10, 32'd4, 32'd0, 1'b0,
                 1'b1, 32'd10, 32'd4, 3'd6, 5'd7, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 2'b11, 6'h3F, 5'd0,  32'd5, 32'd6, 32'd0, 1'b0,
                 1'b1, 32'd5, 32'd6, 3'd1, 5'd0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 2'b10, 6'h20, 5'd1,  32'h11, 32'h22, 32'd0, 1'b0,
                 1'b1, 32'h11, 32'h22, 3'd2, 5'd1, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 2'b10, 6'h22, 5'd2,  32'h33, 32'h44, 32'd0, 1'b0,
                 1'b1, 32'h33, 32'h44, 3'd6, 5'd2, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 2'b10, 6'h24, 5'd3,  32'h55, 32'h66, 32'd0, 1'b0,
                 1'b1, 32'h55, 32'h66, 3'd0, 5'd3, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 2'b10, 6'h25, 5'd4,  32'h77, 32'h88, 32'h1234, 1'b1,
                 1'b1, 32'h77, 32'h1234, 3'd1, 5'd4, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 2'b10, 6'h03, 5'd31, 32'hAAAA, 32'h5555, 32'd0, 1'b0,
                 1'b1, 32'hAAAA, 32'h5555, 3'd0, 5'd31, 1'b1, 8'd1};
    vecs[9]  = '{1'b0, 2'b10, 6'h3F, 5'd3,  32'd7, 32'd8, 32'd0, 1'b0,
                 1'b0, 32'd7, 32'd8, 3'd0, 5'd3, 1'b0, 8'd1};
    vecs[10] = '{1'b1, 2'b10, 6'h00, 5'd0,  32'd1, 32'd2, 32'd0, 1'b0,
                 1'b1, 32'd1, 32'd2, 3'd0, 5'd0, 1'b1, 8'd2};
    vecs[11] = '{1'b1, 2'b10, 6'h2A, 5'd9,  32'h0, 32'h80000000, 32'd0, 1'b0,
                 1'b1, 32'h0, 32'h80000000, 3'd7, 5'd9, 1'b0, 8'd2};

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    rs_idx = 5'd1; rt_idx = 5'd2;
    exmem_we = 1'b0; exmem_rd = 5'd0; exmem_y = 32'd0;
    memwb_we = 1'b0; memwb_rd = 5'd0; memwb_wd = 32'd0;
    drive(1'b1, 2'b10, 6'h03, 5'd5, 32'hDEAD, 32'hBEEF, 32'h1, 1'b0);
    repeat (2) @(negedge clk);
    check_all("reset", 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 8'd0);
    rst_n = 1'b1;

    // Decode/load table, one vector per cycle
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].valid, vecs[i].aluop, vecs[i].funct, vecs[i].sh,
            vecs[i].rs, vecs[i].rt, vecs[i].imm, vecs[i].alusrc);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_a, vecs[i].e_b,
                vecs[i].e_f, vecs[i].e_sh, vecs[i].e_ill, vecs[i].e_cnt);
    end

    // Flush together with stall: bubble, counter untouched
    drive(1'b1, 2'b00, 6'h00, 5'd6, 32'h10, 32'h20, 32'hFFFFFFFC, 1'b1);
    step();
    check_all("pre_flush", 1'b1, 32'h10, 32'hFFFFFFFC, 3'd2, 5'd6, 1'b0, 8'd2);
    flush = 1'b1; stall = 1'b1;
    drive(1'b1, 2'b10, 6'h03, 5'd8, 32'h1, 32'h2, 32'h3, 1'b0);
    step();
    check_all("flush_stall", 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 8'd2);
    flush = 1'b0; stall = 1'b0;

    // Stall for three cycles with changing (including illegal) inputs
    drive(1'b1, 2'b00, 6'h00, 5'd3, 32'h100, 32'h200, 32'd0, 1'b0);
    step();
    check_all("pre_stall", 1'b1, 32'h100, 32'h200, 3'd2, 5'd3, 1'b0, 8'd2);
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 2'b10, 6'h01 + 6'(c), 5'(c + 10), 32'(c + 7), 32'(c + 9), 32'd0, 1'b0);
      step();
      check_all($sformatf("stall%0d", c), 1'b1, 32'h100, 32'h200, 3'd2, 5'd3, 1'b0, 8'd2);
    end
    stall = 1'b0;
    drive(1'b1, 2'b01, 6'h00, 5'd9, 32'h300, 32'h400, 32'd0, 1'b0);
    step();
    check_all("stall_release", 1'b1, 32'h300, 32'h400, 3'd6, 5'd9, 1'b0, 8'd2);

    // Forwarding priority and the register-0 exclusion
    rs_idx = 5'd8; rt_idx = 5'd8;
    exmem_we = 1'b1; exmem_rd = 5'd8; exmem_y = 32'h11;
    memwb_we = 1'b1; memwb_rd = 5'd8; memwb_wd = 32'h22;
    drive(1'b1, 2'b00, 6'h00, 5'd0, 32'h33, 32'h44, 32'd0, 1'b0);
    step();
`ifdef ALU_ISSUE_FWD_EN
    check_all("fwd_exmem", 1'b1, 32'h11, 32'h11, 3'd2, 5'd0, 1'b0, 8'd2);
`else
    check_all("fwd_exmem", 1'b1, 32'h33, 32'h44, 3'd2, 5'd0, 1'b0, 8'd2);
`endif
    exmem_we = 1'b0;
    step();
`ifdef ALU_ISSUE_FWD_EN
    check_all("fwd_memwb", 1'b1, 32'h22, 32'h22, 3'd2, 5'd0, 1'b0, 8'd2);
`else
    check_all("fwd_memwb", 1'b1, 32'h33, 32'h44, 3'd2, 5'd0, 1'b0, 8'd2);
`endif
    exmem_we = 1'b1; rs_idx = 5'd0; rt_idx = 5'd0; exmem_rd = 5'd0; memwb_rd = 5'd0;
    step();
    check_all("fwd_r0", 1'b1, 32'h33, 32'h44, 3'd2, 5'd0, 1'b0, 8'd2);
    exmem_we = 1'b0; memwb_we = 1'b0; rs_idx = 5'd1; rt_idx = 5'd2;

    // Asynchronous reset mid-run clears outputs without a clock edge
    #2 rst_n = 1'b0;
    #1 check_all("async_reset", 1'b0, 32'd0, 32'd0, 3'd0, 5'd0, 1'b0, 8'd0);
    check("async_reset.cnt2", 32'(illegal_cnt2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Five illegal loads: 8-bit counter reaches 5, 2-bit counter saturates at 3
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 2'b10, 6'h03, 5'd1, 32'(n), 32'(n + 1), 32'd0, 1'b0);
      step();
      check_all($sformatf("illegal%0d", n), 1'b1, 32'(n), 32'(n + 1), 3'd0, 5'd1, 1'b1, 8'(n + 1));
      check($sformatf("illegal%0d.cnt2", n), 32'(illegal_cnt2), (n < 2) ? 32'(n + 1) : 32'd3);
      check($sformatf("illegal%0d.ill2", n), 32'(ex_illegal2), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
